// File: rtl/uart_protocol_master.sv
// Host-side initiator for the ASCII UART bus protocol: turns single-byte bus requests
// into "L<addr>", "W<hh>", "R" strings and decodes the two-hex-char read reply.
module uart_protocol_master #(
    parameter bit SKIP_ADDR      = 1'b1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_dat,
    output logic [7:0]  o_dat,
    output logic        o_ack,
    output logic        o_err,
    input  logic        i_target_reset,
    input  logic        i_uart_send_ready,
    output logic        o_uart_send_pulse,
    output logic [7:0]  o_uart_dat,
    input  logic        i_uart_received_pulse,
    input  logic [7:0]  i_uart_dat
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CH_COMMA = 8'h2c;
    localparam logic [7:0] CH_DOT   = 8'h2e;
    localparam logic [7:0] CH_L     = 8'h4c;
    localparam logic [7:0] CH_W     = 8'h57;
    localparam logic [7:0] CH_R     = 8'h52;

    typedef enum logic [3:0] {
        IDLE, SEND_RST, SEND_L, SEND_A, SEND_CMD,
        SEND_D1, SEND_D0, WAIT_R1, WAIT_R0, DONE
    } state_t;

    state_t      state, state_next;
    logic        we_q;
    logic [15:0] addr_q;
    logic [7:0]  wdat_q;
    logic [1:0]  nib_cnt;
    logic [15:0] track_addr;
    logic        track_valid;
    logic        sent_rst;
    logic [TW-1:0] tmo_cnt;
    logic        err_q;

    logic        send;
    logic        capture;
    logic        rst_done;
    logic        acc_hi;
    logic        acc_lo;
    logic        timeout;
    logic [3:0]  addr_nib;
    logic        rx_hex;
    logic [3:0]  rx_nib;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Only lower-case hex is a valid reply digit; 'a'-'f' have bit 6 set.
    assign rx_hex = i_uart_received_pulse &&
                    (((i_uart_dat >= 8'h30) && (i_uart_dat <= 8'h39)) ||
                     ((i_uart_dat >= 8'h61) && (i_uart_dat <= 8'h66)));
    assign rx_nib = i_uart_dat[6] ? (i_uart_dat[3:0] + 4'd9) : i_uart_dat[3:0];

    always_comb begin
        state_next = state;
        send       = 1'b0;
        o_uart_dat = 8'h00;
        capture    = 1'b0;
        rst_done   = 1'b0;
        acc_hi     = 1'b0;
        acc_lo     = 1'b0;
        timeout    = 1'b0;
        addr_nib   = 4'h0;
        case (nib_cnt)
            2'd0:    addr_nib = addr_q[15:12];
            2'd1:    addr_nib = addr_q[11:8];
            2'd2:    addr_nib = addr_q[7:4];
            default: addr_nib = addr_q[3:0];
        endcase
        case (state)
            IDLE: begin
                if (i_target_reset != sent_rst) begin
                    state_next = SEND_RST;
                end else if (i_cs) begin
                    capture    = 1'b1;
                    state_next = (SKIP_ADDR && track_valid && (i_addr == track_addr))
                                 ? SEND_CMD : SEND_L;
                end
            end
            SEND_RST: begin
                o_uart_dat = i_target_reset ? CH_COMMA : CH_DOT;
                send       = i_uart_send_ready;
                if (send) begin
                    rst_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            SEND_L: begin
                o_uart_dat = CH_L;
                send       = i_uart_send_ready;
                if (send) state_next = SEND_A;
            end
            SEND_A: begin
                o_uart_dat = hex_char(addr_nib);
                send       = i_uart_send_ready;
                if (send && (nib_cnt == 2'd3)) state_next = SEND_CMD;
            end
            SEND_CMD: begin
                o_uart_dat = we_q ? CH_W : CH_R;
                send       = i_uart_send_ready;
                if (send) state_next = we_q ? SEND_D1 : WAIT_R1;
            end
            SEND_D1: begin
                o_uart_dat = hex_char(wdat_q[7:4]);
                send       = i_uart_send_ready;
                if (send) state_next = SEND_D0;
            end
            SEND_D0: begin
                o_uart_dat = hex_char(wdat_q[3:0]);
                send       = i_uart_send_ready;
                if (send) state_next = DONE;
            end
            WAIT_R1: begin
                if (rx_hex) begin
                    acc_hi     = 1'b1;
                    state_next = WAIT_R0;
                end else if (tmo_cnt == TMO_MAX) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end
            end
            WAIT_R0: begin
                if (rx_hex) begin
                    acc_lo     = 1'b1;
                    state_next = DONE;
                end else if (tmo_cnt == TMO_MAX) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_uart_send_pulse = send;
    assign o_ack             = (state == DONE);
    assign o_err             = (state == DONE) && err_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdat_q      <= 8'h00;
            nib_cnt     <= 2'd0;
            track_addr  <= 16'h0000;
            track_valid <= 1'b0;
            sent_rst    <= 1'b0;
            tmo_cnt     <= '0;
            err_q       <= 1'b0;
            o_dat       <= 8'h00;
        end else begin
            state <= state_next;
            if (capture) begin
                we_q   <= i_we;
                addr_q <= i_addr;
                wdat_q <= i_dat;
                err_q  <= 1'b0;
            end
            if ((state == SEND_A) && send) nib_cnt <= nib_cnt + 2'd1;
            if (rst_done) begin
                sent_rst    <= i_target_reset;
                track_valid <= 1'b0;
            end
            // Timer restarts for each reply character; junk bytes do not restart it.
            if (((state == SEND_CMD) && (state_next == WAIT_R1)) || acc_hi) begin
                tmo_cnt <= '0;
            end else if ((state == WAIT_R1) || (state == WAIT_R0)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (acc_hi) o_dat[7:4] <= rx_nib;
            if (acc_lo) o_dat[3:0] <= rx_nib;
            if (timeout) begin
                o_dat       <= 8'h00;
                err_q       <= 1'b1;
                track_valid <= 1'b0;
            end
            if ((state == DONE) && !err_q) begin
                track_addr  <= addr_q + 16'd1;
                track_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_protocol_master.sv
// Randomized bench for uart_protocol_master: a string-level model predicts the TX byte
// stream and each acknowledge; a responder plays the remote target on the RX side.
module tb_uart_protocol_master;

    localparam int TMO = 16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cs;
    logic        i_we;
    logic [15:0] i_addr;
    logic [7:0]  i_dat;
    logic [7:0]  o_dat;
    logic        o_ack;
    logic        o_err;
    logic        i_target_reset;
    logic        i_uart_send_ready;
    logic        o_uart_send_pulse;
    logic [7:0]  o_uart_dat;
    logic        i_uart_received_pulse;
    logic [7:0]  i_uart_dat;

    uart_protocol_master #(.SKIP_ADDR(1'b1), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cs(i_cs), .i_we(i_we),
        .i_addr(i_addr), .i_dat(i_dat), .o_dat(o_dat), .o_ack(o_ack), .o_err(o_err),
        .i_target_reset(i_target_reset), .i_uart_send_ready(i_uart_send_ready),
        .o_uart_send_pulse(o_uart_send_pulse), .o_uart_dat(o_uart_dat),
        .i_uart_received_pulse(i_uart_received_pulse), .i_uart_dat(i_uart_dat)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [1:0] kind;   // 0 write, 1 read ok, 2 read timeout
        logic       err;
        logic [7:0] dat;
    } ack_t;

    logic [7:0]  exp_q[$];
    ack_t        ack_q[$];
    logic [15:0] m_track;
    bit          m_valid;
    bit          m_sent;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, last_tx_cyc = 0, last_rx_cyc = 0, r_cyc = 0, ack_cyc = 0;

    int          ready_mode = 0;
    bit          rd_ok;
    logic [7:0]  rd_val;
    logic [7:0]  rd_junk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] hexc(input int n);
        string digits;
        digits = "0123456789abcdef";
        return digits[n];
    endfunction

    // ---------------- reference model ----------------
    task automatic model_txn(input bit we, input logic [15:0] addr, input logic [7:0] dat,
                             input bit trst, input bit ok);
        if (trst != m_sent) begin
            exp_q.push_back(trst ? 8'h2c : 8'h2e);
            m_sent  = trst;
            m_valid = 0;
        end
        if (!(m_valid && addr == m_track)) begin
            exp_q.push_back(8'h4c);
            for (int i = 3; i >= 0; i--) exp_q.push_back(hexc((addr >> (4 * i)) % 16));
        end
        if (we) begin
            exp_q.push_back(8'h57);
            exp_q.push_back(hexc(dat / 16));
            exp_q.push_back(hexc(dat % 16));
            ack_q.push_back('{kind: 2'd0, err: 1'b0, dat: 8'h00});
        end else begin
            exp_q.push_back(8'h52);
            if (ok) ack_q.push_back('{kind: 2'd1, err: 1'b0, dat: dat});
            else    ack_q.push_back('{kind: 2'd2, err: 1'b1, dat: 8'h00});
        end
        if (we || ok) begin
            m_track = addr + 16'd1;
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        cyc++;
        if (o_uart_send_pulse) begin
            last_tx_cyc = cyc;
            if (o_uart_dat == 8'h52) r_cyc = cyc;
            if (exp_q.size() == 0) check("tx_extra", {24'h0, o_uart_dat}, 32'h0);
            else                   check("tx_byte", {24'h0, o_uart_dat}, {24'h0, exp_q.pop_front()});
        end
        if (i_uart_received_pulse &&
            ((i_uart_dat >= 8'h30 && i_uart_dat <= 8'h39) ||
             (i_uart_dat >= 8'h61 && i_uart_dat <= 8'h66)))
            last_rx_cyc = cyc;
        if (o_ack) begin
            ack_t a;
            ack_cyc = cyc;
            if (ack_q.size() == 0) begin
                check("ack_extra", {31'h0, o_ack}, 32'h0);
            end else begin
                a = ack_q.pop_front();
                check("ack_err", {31'h0, o_err}, {31'h0, a.err});
                if (a.kind != 2'd0) check("rd_dat", {24'h0, o_dat}, {24'h0, a.dat});
                if (a.kind == 2'd0) check("wr_ack_lat", cyc - last_tx_cyc, 1);
                if (a.kind == 2'd1) check("rd_ack_lat", cyc - last_rx_cyc, 1);
            end
        end
    end

    // ---------------- drivers ----------------
    always begin
        @(posedge i_clk);
        #1;
        case (ready_mode)
            0:       i_uart_send_ready = 1'b1;
            1:       i_uart_send_ready = ~i_uart_send_ready;
            default: i_uart_send_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic rx_byte(input logic [7:0] b);
        @(posedge i_clk);
        #1;
        i_uart_received_pulse = 1'b1;
        i_uart_dat            = b;
        @(posedge i_clk);
        #1;
        i_uart_received_pulse = 1'b0;
        i_uart_dat            = 8'h00;
    endtask

    // Remote target: answers 'R' with two hex chars (optionally junk first); a stray
    // hex byte after 'W' arrives while no reply is awaited.
    initial begin
        i_uart_received_pulse = 1'b0;
        i_uart_dat            = 8'h00;
        forever begin
            @(negedge i_clk);
            if (o_uart_send_pulse && o_uart_dat == 8'h52 && rd_ok) begin
                repeat ($urandom_range(0, 3)) @(posedge i_clk);
                if (rd_junk != 8'h00) rx_byte(rd_junk);
                repeat ($urandom_range(0, 3)) @(posedge i_clk);
                rx_byte(hexc(rd_val / 16));
                repeat ($urandom_range(0, 4)) @(posedge i_clk);
                rx_byte(hexc(rd_val % 16));
            end else if (o_uart_send_pulse && o_uart_dat == 8'h57) begin
                rx_byte(hexc($urandom_range(0, 15)));
            end
        end
    end

    task automatic wait_ack(input string tag);
        bit got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge i_clk);
            #1;
            got = o_ack;
        end
        if (!got) check(tag, {31'h0, o_ack}, 32'h1);
    endtask

    task automatic wait_q(input int n, input string tag);
        for (int k = 0; k < 300 && exp_q.size() > n; k++) begin
            @(negedge i_clk);
            #1;
        end
        check(tag, exp_q.size(), n);
    endtask

    task automatic start_txn(input bit we, input logic [15:0] addr, input logic [7:0] dat,
                             input bit trst, input bit ok, input logic [7:0] junk);
        model_txn(we, addr, dat, trst, ok);
        rd_ok   = ok;
        rd_val  = dat;
        rd_junk = junk;
        @(posedge i_clk);
        #1;
        i_target_reset = trst;
        i_cs   = 1'b1;
        i_we   = we;
        i_addr = addr;
        i_dat  = dat;
    endtask

    task automatic end_txn();
        @(posedge i_clk);
        #1;
        i_cs   = 1'b0;
        i_addr = 16'($urandom);
        i_dat  = 8'($urandom);
    endtask

    task automatic txn(input bit we, input logic [15:0] addr, input logic [7:0] dat,
                       input bit trst, input bit ok, input logic [7:0] junk);
        start_txn(we, addr, dat, trst, ok, junk);
        wait_ack("ack_timeout");
        end_txn();
    endtask

    task automatic do_reset(input string tag);
        @(posedge i_clk);
        #1;
        i_reset        = 1'b1;
        i_cs           = 1'b0;
        i_target_reset = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check({tag, "_ack"},   {31'h0, o_ack}, 32'h0);
        check({tag, "_err"},   {31'h0, o_err}, 32'h0);
        check({tag, "_pulse"}, {31'h0, o_uart_send_pulse}, 32'h0);
        check({tag, "_txdat"}, {24'h0, o_uart_dat}, 32'h0);
        check({tag, "_odat"},  {24'h0, o_dat}, 32'h0);
        #1;
        exp_q.delete();
        ack_q.delete();
        m_valid = 0;
        m_sent  = 0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        i_reset = 1'b1; i_cs = 1'b0; i_we = 1'b0; i_addr = 16'h0; i_dat = 8'h0;
        i_target_reset = 1'b0; i_uart_send_ready = 1'b1;
        rd_ok = 0; rd_val = 8'h0; rd_junk = 8'h0;
        m_track = 16'h0; m_valid = 0; m_sent = 0;
        repeat (2) @(posedge i_clk);
        do_reset("reset");

        // Full write, then sequential write that skips the address phase
        txn(1, 16'h1a00, 8'h4d, 0, 1, 8'h00);
        txn(1, 16'h1a01, 8'h00, 0, 1, 8'h00);
        // Read with a junk byte ahead of the reply
        txn(0, 16'h1234, 8'h3f, 0, 1, 8'h78);
        // Silent target: timeout after TMO cycles in the first wait
        txn(0, 16'h1235, 8'h00, 0, 0, 8'h00);
        check("tmo_lat", ack_cyc - r_cyc, TMO + 1);
        txn(0, 16'h1235, 8'ha7, 0, 1, 8'h47);

        // Target reset raised and dropped while a write is in flight
        model_txn(1, 16'h2000, 8'h81, 0, 1);
        exp_q.push_back(8'h2c);
        exp_q.push_back(8'h2e);
        rd_ok = 1;
        @(posedge i_clk);
        #1;
        i_cs = 1'b1; i_we = 1'b1; i_addr = 16'h2000; i_dat = 8'h81;
        repeat (2) @(posedge i_clk);
        #1;
        i_target_reset = 1'b1;
        wait_ack("trst_ack_timeout");
        end_txn();
        wait_q(1, "trst_comma");
        @(posedge i_clk);
        #1;
        i_target_reset = 1'b0;
        wait_q(0, "trst_dot");
        m_valid = 0;
        txn(1, 16'h2001, 8'h5e, 0, 1, 8'h00);

        // Address wrap: 0xffff then 0x0000 skips the address phase
        txn(1, 16'hffff, 8'hc3, 0, 1, 8'h00);
        txn(1, 16'h0000, 8'h3c, 0, 1, 8'h00);
        txn(0, 16'h0001, 8'he9, 0, 1, 8'h3a);

        // Back-pressure: ready toggles every cycle
        ready_mode = 1;
        txn(1, 16'h0a5c, 8'hb2, 0, 1, 8'h00);
        txn(0, 16'h0a5d, 8'h60, 0, 1, 8'h60);

        // Reset in the middle of "L12..."
        start_txn(1, 16'h12ab, 8'h55, 0, 1, 8'h00);
        wait_q(exp_q.size() - 3, "mid_progress");
        do_reset("midreset");
        repeat (3) @(negedge i_clk);
        #1;
        check("midreset_no_tx", exp_q.size(), 0);
        txn(1, 16'h12ab, 8'h55, 0, 1, 8'h00);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            bit          we;
            bit          ok;
            bit          trst;
            logic [15:0] addr;
            logic [7:0]  junk;
            logic [7:0]  junk_tab[4];
            junk_tab[0] = 8'h2f; junk_tab[1] = 8'h3a; junk_tab[2] = 8'h67; junk_tab[3] = 8'h41;
            ready_mode = $urandom_range(0, 2);
            we   = 1'($urandom_range(0, 1));
            ok   = ($urandom_range(0, 3) != 0);
            trst = ($urandom_range(0, 7) == 0) ? ~m_sent : m_sent;
            addr = ($urandom_range(0, 1) == 1) ? m_track : 16'($urandom);
            junk = ($urandom_range(0, 1) == 1) ? junk_tab[$urandom_range(0, 3)] : 8'h00;
            txn(we, addr, 8'($urandom), trst, ok, junk);
            repeat ($urandom_range(0, 2)) @(posedge i_clk);
        end

        repeat (6) @(negedge i_clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("ack_q_drained", ack_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
